solver_dispatch: RTL and testbench
==================================

SOLVER_DISPATCH -- requirements
Module: solver_dispatch

Interface
REQ-001 SHALL have parameter LIMB_INDEX_BITS, default 6, limb index width.
REQ-002 SHALL have parameter LIMB_BITS, default 32, limb data width.
REQ-003 SHALL have ports clock (in, 1, clock) and reset (in, 1, reset), synchronous, active-high.
REQ-004 SHALL have cfg_num_limbs (in, LIMB_INDEX_BITS, limbs per operand) and cfg_iter_lim (in, 16, iteration limit); both sampled at job accept.
REQ-005 SHALL have job_valid (in, 1), job_ready (out, 1), job_data (in, LIMB_BITS) and job_tag (in, 8), forming the limb stream; job_tag is valid on the first beat.
REQ-006 SHALL have solver-side outputs: wr_real_en (1), wr_imag_en (1), wr_ind (LIMB_INDEX_BITS), limb_data (LIMB_BITS), wr_num_limbs_en (1), num_limbs_data (LIMB_INDEX_BITS), wr_iter_lim_en (1), iter_lim_data (16) and start (1).
REQ-007 SHALL have solver-side inputs out_ready (1, solve done) and iteration_count (16).
REQ-008 SHALL have res_valid (out, 1), res_ready (in, 1), res_tag (out, 8), res_count (out, 16), res_escaped (out, 1) and busy (out, 1).

Function
REQ-009 SHALL implement FSM states IDLE, CFG, LOAD_RE, LOAD_IM, START, WAIT_DROP, WAIT_DONE and RESULT.
REQ-010 IDLE: job_ready=0; on job_valid, SHALL latch cfg_num_limbs (0 clamped to 1), cfg_iter_lim and job_tag, then go to CFG.
REQ-011 CFG (1 cycle): SHALL assert wr_num_limbs_en and wr_iter_lim_en with the latched values, clear the limb counter, then go to LOAD_RE.
REQ-012 LOAD_RE: job_ready=1; each handshake (job_valid & job_ready) SHALL assert wr_real_en in the same cycle, with wr_ind = counter and limb_data = job_data (combinational passthrough); after the N-th beat SHALL clear the counter and go to LOAD_IM.
REQ-013 LOAD_IM: same as LOAD_RE but with wr_imag_en; after the N-th beat SHALL go to START.
REQ-014 SHALL issue real limb index 0 first; the stream order is re[0..N-1] then im[0..N-1], exactly 2N beats per job.
REQ-015 job_valid low mid-load SHALL stall without writes; the counter holds.
REQ-016 START: SHALL pulse start for exactly 1 cycle, then go to WAIT_DROP.
REQ-017 WAIT_DROP: SHALL wait until out_ready=0 (expected the next cycle), then go to WAIT_DONE; a stale out_ready=1 from the previous job SHALL NOT be taken as completion.
REQ-018 WAIT_DONE: on out_ready=1, SHALL capture iteration_count into res_count and go to RESULT.
REQ-019 RESULT: res_valid=1, with res_tag, res_count and res_escaped held stable; res_escaped = (res_count != 16'hFFFF); on res_ready SHALL go to IDLE.
REQ-020 A new job SHALL NOT be accepted until the result handshake completes (one job in flight).
REQ-021 busy=1 in all states except IDLE.
REQ-022 All solver write enables and start SHALL be 0 outside their states; wr_ind=0 and limb_data=0 when idle.
REQ-023 cfg_* changes after job accept SHALL NOT affect the job in flight.
REQ-024 N = 2^LIMB_INDEX_BITS-1 (max) SHALL load correctly without counter wrap.

Reset
REQ-025 Reset SHALL force IDLE and zero all outputs, counters, latched tag, count and configuration, on the next clock edge.
REQ-026 Reset mid-load or mid-solve SHALL abandon the job with no result; beats already consumed are lost.

Structure
REQ-027 Package fractal_pkg SHALL hold the dispatch FSM state enum and the constant NO_ESCAPE_COUNT = 16'hFFFF.
REQ-028 SHALL be a single module with no sub-modules; the limb counter is inline.

Verification
REQ-029 N=2, iter_lim=100, tag=0x5A, stream re=1,2 im=3,4; solver model returns 37 -> CFG writes num_limbs=2, iter=100; writes at re ind0=1, ind1=2, im ind0=3, ind1=4; one start pulse; result tag=0x5A, count=37, escaped=1.
REQ-030 Solver model returns 0xFFFF -> res_count=0xFFFF, res_escaped=0.
REQ-031 job_valid toggled 0/1 every cycle during load, N=3 -> exactly 6 writes, indices in order, no duplicates.
REQ-032 res_ready held low 10 cycles with job_valid=1 -> result stable, job_ready=0, no CFG until accept.
REQ-033 cfg_num_limbs=0 -> treated as N=1: 2 beats, num_limbs_data=1.
REQ-034 Reset asserted in WAIT_DONE -> IDLE next cycle, res_valid=0, busy=0; next job completes normally.

Source files
------------

// File: rtl/fractal_pkg.sv
// Shared types and constants for the fractal solver dispatch logic.
package fractal_pkg;

    typedef enum logic [2:0] {
        DS_IDLE      = 3'd0,
        DS_CFG       = 3'd1,
        DS_LOAD_RE   = 3'd2,
        DS_LOAD_IM   = 3'd3,
        DS_START     = 3'd4,
        DS_WAIT_DROP = 3'd5,
        DS_WAIT_DONE = 3'd6,
        DS_RESULT    = 3'd7
    } dispatch_state_e;

    localparam logic [15:0] NO_ESCAPE_COUNT = 16'hFFFF;

endpackage

// File: rtl/solver_dispatch_if.sv
// Host-side job stream, configuration and result handshake for solver_dispatch.
interface solver_dispatch_if #(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32
);
    logic [LIMB_INDEX_BITS-1:0] cfg_num_limbs;
    logic [15:0]                cfg_iter_lim;
    logic                       job_valid;
    logic                       job_ready;
    logic [LIMB_BITS-1:0]       job_data;
    logic [7:0]                 job_tag;
    logic                       res_valid;
    logic                       res_ready;
    logic [7:0]                 res_tag;
    logic [15:0]                res_count;
    logic                       res_escaped;

    modport master (
        output cfg_num_limbs, cfg_iter_lim, job_valid, job_data, job_tag, res_ready,
        input  job_ready, res_valid, res_tag, res_count, res_escaped
    );

    modport slave (
        input  cfg_num_limbs, cfg_iter_lim, job_valid, job_data, job_tag, res_ready,
        output job_ready, res_valid, res_tag, res_count, res_escaped
    );
endinterface

// File: rtl/solver_dispatch.sv
// Streams one job's real/imag limbs into a fractal solver, starts it and
// returns the iteration count; strictly one job in flight.
module solver_dispatch
    import fractal_pkg::*;
#(
    parameter int LIMB_INDEX_BITS = 6,
    parameter int LIMB_BITS       = 32
) (
    input  logic                       clock,
    input  logic                       reset,
    solver_dispatch_if.slave           host,
    output logic                       wr_real_en,
    output logic                       wr_imag_en,
    output logic [LIMB_INDEX_BITS-1:0] wr_ind,
    output logic [LIMB_BITS-1:0]       limb_data,
    output logic                       wr_num_limbs_en,
    output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
    output logic                       wr_iter_lim_en,
    output logic [15:0]                iter_lim_data,
    output logic                       start,
    input  logic                       out_ready,
    input  logic [15:0]                iteration_count,
    output logic                       busy
);

    localparam logic [LIMB_INDEX_BITS-1:0] IDX_ZERO = {LIMB_INDEX_BITS{1'b0}};
    localparam logic [LIMB_INDEX_BITS-1:0] IDX_ONE  = LIMB_INDEX_BITS'(1);

    dispatch_state_e              state_q, state_d;
    logic [LIMB_INDEX_BITS-1:0]   cnt_q, cnt_d;
    logic [LIMB_INDEX_BITS-1:0]   n_q, n_d;
    logic [15:0]                  iter_q, iter_d;
    logic [7:0]                   tag_q, tag_d;
    logic [15:0]                  count_q, count_d;
    logic                         last_beat_s;
    logic                         job_ready_s;

    assign last_beat_s = (cnt_q == (n_q - IDX_ONE));

    // Next-state, counter and solver-side strobes for every dispatch phase.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        n_d             = n_q;
        iter_d          = iter_q;
        tag_d           = tag_q;
        count_d         = count_q;
        job_ready_s     = 1'b0;
        wr_real_en      = 1'b0;
        wr_imag_en      = 1'b0;
        wr_ind          = IDX_ZERO;
        limb_data       = {LIMB_BITS{1'b0}};
        wr_num_limbs_en = 1'b0;
        num_limbs_data  = IDX_ZERO;
        wr_iter_lim_en  = 1'b0;
        iter_lim_data   = 16'h0000;
        start           = 1'b0;
        case (state_q)
            DS_IDLE: begin
                if (host.job_valid) begin
                    n_d     = (host.cfg_num_limbs == IDX_ZERO) ? IDX_ONE : host.cfg_num_limbs;
                    iter_d  = host.cfg_iter_lim;
                    tag_d   = host.job_tag;
                    state_d = DS_CFG;
                end else begin
                    state_d = DS_IDLE;
                end
            end
            DS_CFG: begin
                wr_num_limbs_en = 1'b1;
                num_limbs_data  = n_q;
                wr_iter_lim_en  = 1'b1;
                iter_lim_data   = iter_q;
                cnt_d           = IDX_ZERO;
                state_d         = DS_LOAD_RE;
            end
            DS_LOAD_RE, DS_LOAD_IM: begin
                job_ready_s = 1'b1;
                if (host.job_valid) begin
                    wr_real_en = (state_q == DS_LOAD_RE);
                    wr_imag_en = (state_q == DS_LOAD_IM);
                    wr_ind     = cnt_q;
                    limb_data  = host.job_data;
                    if (last_beat_s) begin
                        cnt_d   = IDX_ZERO;
                        state_d = (state_q == DS_LOAD_RE) ? DS_LOAD_IM : DS_START;
                    end else begin
                        cnt_d   = cnt_q + IDX_ONE;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            DS_START: begin
                start   = 1'b1;
                state_d = DS_WAIT_DROP;
            end
            // out_ready may still be high from the previous solve; wait for it to fall.
            DS_WAIT_DROP: begin
                if (!out_ready) begin
                    state_d = DS_WAIT_DONE;
                end else begin
                    state_d = DS_WAIT_DROP;
                end
            end
            DS_WAIT_DONE: begin
                if (out_ready) begin
                    count_d = iteration_count;
                    state_d = DS_RESULT;
                end else begin
                    state_d = DS_WAIT_DONE;
                end
            end
            DS_RESULT: begin
                if (host.res_ready) begin
                    state_d = DS_IDLE;
                end else begin
                    state_d = DS_RESULT;
                end
            end
            default: begin
                state_d = DS_IDLE;
            end
        endcase
    end

    // State and job context registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= DS_IDLE;
            cnt_q   <= IDX_ZERO;
            n_q     <= IDX_ZERO;
            iter_q  <= 16'h0000;
            tag_q   <= 8'h00;
            count_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            iter_q  <= iter_d;
            tag_q   <= tag_d;
            count_q <= count_d;
        end
    end

    assign host.job_ready   = job_ready_s;
    assign host.res_valid   = (state_q == DS_RESULT);
    assign host.res_tag     = tag_q;
    assign host.res_count   = count_q;
    assign host.res_escaped = (state_q == DS_RESULT) && (count_q != NO_ESCAPE_COUNT);
    assign busy             = (state_q != DS_IDLE);

endmodule

// File: tb/tb_solver_dispatch.sv
// Directed bench for solver_dispatch: host stream driver plus an inline solver model.
module tb_solver_dispatch;

    logic        clock = 1'b0;
    logic        reset;
    logic        wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start, busy;
    logic [5:0]  wr_ind, num_limbs_data;
    logic [31:0] limb_data;
    logic [15:0] iter_lim_data;
    logic        out_ready;
    logic [15:0] iteration_count;

    int compared = 0;
    int mismatched = 0;

    // Write log, refreshed every cycle on the falling edge.
    logic [31:0] re_mem [64];
    logic [31:0] im_mem [64];
    int re_n, im_n, ord_err, start_n, nl_n;
    logic [5:0]  nl_v;
    logic [15:0] iter_v;
    logic        hs;

    solver_dispatch_if #(.LIMB_INDEX_BITS(6), .LIMB_BITS(32)) host ();

    solver_dispatch #(.LIMB_INDEX_BITS(6), .LIMB_BITS(32)) dut (
        .clock           (clock),
        .reset           (reset),
        .host            (host.slave),
        .wr_real_en      (wr_real_en),
        .wr_imag_en      (wr_imag_en),
        .wr_ind          (wr_ind),
        .limb_data       (limb_data),
        .wr_num_limbs_en (wr_num_limbs_en),
        .num_limbs_data  (num_limbs_data),
        .wr_iter_lim_en  (wr_iter_lim_en),
        .iter_lim_data   (iter_lim_data),
        .start           (start),
        .out_ready       (out_ready),
        .iteration_count (iteration_count),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        re_n = 0; im_n = 0; ord_err = 0; start_n = 0; nl_n = 0;
        nl_v = 6'd0; iter_v = 16'd0;
    endtask

    // One cycle: log solver-side strobes at negedge, return just after posedge.
    task automatic tick();
        @(negedge clock);
        hs = host.job_valid && host.job_ready;
        if (wr_real_en) begin
            if (wr_ind !== 6'(re_n)) ord_err++;
            if (re_n < 64) re_mem[re_n] = limb_data;
            re_n++;
        end
        if (wr_imag_en) begin
            if (wr_ind !== 6'(im_n)) ord_err++;
            if (im_n < 64) im_mem[im_n] = limb_data;
            im_n++;
        end
        if (start) start_n++;
        if (wr_num_limbs_en) begin
            nl_n++;
            nl_v   = num_limbs_data;
            iter_v = iter_lim_data;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic run_job(input logic [7:0] tag, input logic [5:0] cfg_n, input int n,
                           input logic [15:0] iter, input logic [31:0] bre, input logic [31:0] bim,
                           input logic [15:0] cnt, input bit toggle, input int hold);
        int b;
        int g;
        logic exp_esc;
        clear_log();
        b = 0;
        g = 0;
        host.cfg_num_limbs = cfg_n;
        host.cfg_iter_lim  = iter;
        host.job_tag       = tag;
        while (b < 2 * n && g < 2000) begin
            host.job_valid = toggle ? (g % 2 == 0) : 1'b1;
            host.job_data  = (b < n) ? bre + 32'(b) : bim + 32'(b - n);
            tick();
            if (hs) b++;
            // Config and tag changes after acceptance must not reach this job.
            host.cfg_num_limbs = 6'd5;
            host.cfg_iter_lim  = 16'd7;
            host.job_tag       = 8'hFF;
            g++;
        end
        host.job_valid = 1'b0;
        check("beats_consumed", 32'(b), 32'(2 * n));
        g = 0;
        while (start_n == 0 && g < 50) begin
            tick();
            g++;
        end
        check("start_seen", 32'(start_n), 32'd1);
        tick();
        check("stale_out_ready_ignored", {31'd0, host.res_valid}, 32'd0);
        out_ready = 1'b0;
        repeat (3) tick();
        check("solving_busy", {31'd0, busy}, 32'd1);
        check("solving_no_result", {31'd0, host.res_valid}, 32'd0);
        iteration_count = cnt;
        out_ready = 1'b1;
        tick();
        exp_esc = (cnt != 16'hFFFF);
        check("res_valid", {31'd0, host.res_valid}, 32'd1);
        check("res_tag", {24'd0, host.res_tag}, {24'd0, tag});
        check("res_count", {16'd0, host.res_count}, {16'd0, cnt});
        check("res_escaped", {31'd0, host.res_escaped}, {31'd0, exp_esc});
        iteration_count = 16'h1234;
        for (int i = 0; i < hold; i++) begin
            host.job_valid = 1'b1;
            tick();
            check("hold_res_valid", {31'd0, host.res_valid}, 32'd1);
            check("hold_job_ready", {31'd0, host.job_ready}, 32'd0);
            check("hold_res_count", {16'd0, host.res_count}, {16'd0, cnt});
        end
        host.job_valid = 1'b0;
        host.res_ready = 1'b1;
        tick();
        host.res_ready = 1'b0;
        check("post_res_valid", {31'd0, host.res_valid}, 32'd0);
        check("post_busy", {31'd0, busy}, 32'd0);
        check("start_pulses", 32'(start_n), 32'd1);
        check("cfg_writes", 32'(nl_n), 32'd1);
        check("cfg_num_limbs", {26'd0, nl_v}, {26'd0, 6'(n)});
        check("cfg_iter_lim", {16'd0, iter_v}, {16'd0, iter});
        check("re_writes", 32'(re_n), 32'(n));
        check("im_writes", 32'(im_n), 32'(n));
        check("index_order", 32'(ord_err), 32'd0);
        check("re_first", re_mem[0], bre);
        check("re_last", re_mem[n - 1], bre + 32'(n - 1));
        check("im_first", im_mem[0], bim);
        check("im_last", im_mem[n - 1], bim + 32'(n - 1));
    endtask

    initial begin
        reset              = 1'b1;
        host.cfg_num_limbs = 6'd0;
        host.cfg_iter_lim  = 16'd0;
        host.job_valid     = 1'b0;
        host.job_data      = 32'd0;
        host.job_tag       = 8'd0;
        host.res_ready     = 1'b0;
        out_ready          = 1'b1;
        iteration_count    = 16'd0;
        clear_log();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_res_valid", {31'd0, host.res_valid}, 32'd0);
        check("rst_res_tag", {24'd0, host.res_tag}, 32'd0);
        check("rst_res_count", {16'd0, host.res_count}, 32'd0);
        check("rst_res_escaped", {31'd0, host.res_escaped}, 32'd0);
        check("rst_job_ready", {31'd0, host.job_ready}, 32'd0);
        check("rst_strobes", {26'd0, wr_real_en, wr_imag_en, wr_num_limbs_en, wr_iter_lim_en, start, 1'b0}, 32'd0);
        check("rst_wr_ind", {26'd0, wr_ind}, 32'd0);
        check("rst_limb_data", limb_data, 32'd0);

        // Basic job with held-off result handshake.
        run_job(8'h5A, 6'd2, 2, 16'd100, 32'd1, 32'd3, 16'd37, 1'b0, 10);
        // Non-escaping point, num_limbs=0 clamps to one.
        run_job(8'hC3, 6'd0, 1, 16'd500, 32'hAA, 32'hBB, 16'hFFFF, 1'b0, 0);
        // Bubbly stream.
        run_job(8'h11, 6'd3, 3, 16'd20, 32'd10, 32'd20, 16'd5, 1'b1, 0);
        // Largest operand size.
        run_job(8'h7E, 6'd63, 63, 16'hFFFE, 32'd100, 32'd200, 16'h0100, 1'b0, 0);

        // Reset while the solver is running abandons the job.
        host.cfg_num_limbs = 6'd1;
        host.cfg_iter_lim  = 16'd9;
        host.job_tag       = 8'h42;
        host.job_data      = 32'h55;
        host.job_valid     = 1'b1;
        repeat (4) tick();
        host.job_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        repeat (2) tick();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_res_valid", {31'd0, host.res_valid}, 32'd0);
        check("mid_reset_res_count", {16'd0, host.res_count}, 32'd0);
        out_ready = 1'b1;
        iteration_count = 16'd77;
        repeat (2) tick();
        check("abandoned_no_result", {31'd0, host.res_valid}, 32'd0);
        check("abandoned_idle", {31'd0, busy}, 32'd0);
        run_job(8'h99, 6'd2, 2, 16'd64, 32'h1000, 32'h2000, 16'd12, 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
